// File: rtl/wallace_pkg.sv
// Shared definitions for the Wallace-tree frame summer: FSM states and
// the operand group size that one tree pass absorbs.
package wallace_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        ADD     = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int GROUP  = 5;
    localparam int FILL_W = $clog2(GROUP + 1);

endpackage

// File: rtl/Wallace_adder.sv
// Six-operand Wallace tree: three carry-save levels reduce six words to
// two, and one carry-propagate adder produces the modulo-2^WORDLEN sum.
module Wallace_adder #(
    parameter int WORDLEN = 8
) (
    input  logic [WORDLEN-1:0] op0,
    input  logic [WORDLEN-1:0] op1,
    input  logic [WORDLEN-1:0] op2,
    input  logic [WORDLEN-1:0] op3,
    input  logic [WORDLEN-1:0] op4,
    input  logic [WORDLEN-1:0] op5,
    output logic [WORDLEN-1:0] sum
);
    logic [WORDLEN-1:0] s1a, c1a, s1b, c1b;
    logic [WORDLEN-1:0] s2, c2, s3, c3;

    // Carries are shifted left one place; the bit falling off the top is
    // the modulo-2^WORDLEN wrap.
    assign s1a = op0 ^ op1 ^ op2;
    assign c1a = ((op0 & op1) | (op0 & op2) | (op1 & op2)) << 1;
    assign s1b = op3 ^ op4 ^ op5;
    assign c1b = ((op3 & op4) | (op3 & op5) | (op4 & op5)) << 1;

    assign s2  = s1a ^ c1a ^ s1b;
    assign c2  = ((s1a & c1a) | (s1a & s1b) | (c1a & s1b)) << 1;

    assign s3  = s2 ^ c2 ^ c1b;
    assign c3  = ((s2 & c2) | (s2 & c1b) | (c2 & c1b)) << 1;

    assign sum = s3 + c3;

endmodule

// File: rtl/wallace_sum_sched.sv
// Frame summer: buffers up to five operands at a time, folds them into a
// running accumulator through one Wallace tree, and returns the frame sum.
module wallace_sum_sched
    import wallace_pkg::*;
#(
    parameter int WORDLEN = 8,
    parameter int CNTW    = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [CNTW-1:0]    op_count,
    input  logic               in_valid,
    input  logic [WORDLEN-1:0] in_data,
    output logic               in_ready,
    output logic               out_valid,
    output logic [WORDLEN-1:0] out_sum,
    input  logic               out_ready,
    output logic               busy
);
    state_t             state_q, state_d;
    logic [WORDLEN-1:0] acc_q;
    logic [CNTW-1:0]    remaining_q;
    logic [FILL_W-1:0]  fill_q;
    logic [WORDLEN-1:0] slot_q [GROUP];
    logic [WORDLEN-1:0] tree_sum;
    logic               accept;

    assign accept = in_valid && in_ready;

    // NOTE: registers update with non-blocking assignments so every flop
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of a combinational block gets a default first so
    // no path through the case leaves it unassigned and infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (op_count == '0) ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                if (accept && (fill_q == FILL_W'(GROUP - 1) ||
                               remaining_q == CNTW'(1))) begin
                    state_d = ADD;
                end
            end
            ADD: begin
                state_d = (remaining_q == '0) ? DONE : COLLECT;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decode registered state only; no input feeds them.
    always_comb begin
        busy      = (state_q != IDLE);
        in_ready  = (state_q == COLLECT) && (fill_q < FILL_W'(GROUP)) &&
                    (remaining_q != '0);
        out_valid = (state_q == DONE);
        out_sum   = out_valid ? acc_q : '0;
    end

    // NOTE: the five-slot buffer is reset along with the rest of the
    // datapath because empty slots must read as zero into the tree.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            remaining_q <= '0;
            fill_q      <= '0;
            for (int i = 0; i < GROUP; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        remaining_q <= op_count;
                        acc_q       <= '0;
                    end
                end
                COLLECT: begin
                    if (accept) begin
                        for (int i = 0; i < GROUP; i++) begin
                            if (fill_q == FILL_W'(i)) begin
                                slot_q[i] <= in_data;
                            end
                        end
                        fill_q      <= fill_q + FILL_W'(1);
                        remaining_q <= remaining_q - CNTW'(1);
                    end
                end
                ADD: begin
                    acc_q  <= tree_sum;
                    fill_q <= '0;
                    for (int i = 0; i < GROUP; i++) begin
                        slot_q[i] <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    Wallace_adder #(
        .WORDLEN(WORDLEN)
    ) u_tree (
        .op0(acc_q),
        .op1(slot_q[0]),
        .op2(slot_q[1]),
        .op3(slot_q[2]),
        .op4(slot_q[3]),
        .op5(slot_q[4]),
        .sum(tree_sum)
    );

endmodule

// File: tb/tb_wallace_sum_sched.sv
// Self-checking bench for wallace_sum_sched: a frame-level scoreboard checks
// sums, latency, pass counts and handshake rules on every falling edge.
module tb_wallace_sum_sched;
    localparam int WORDLEN = 8;
    localparam int CNTW    = 7;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [CNTW-1:0]    op_count = '0;
    logic               in_valid = 1'b0;
    logic [WORDLEN-1:0] in_data = '0;
    logic               in_ready;
    logic               out_valid;
    logic [WORDLEN-1:0] out_sum;
    logic               out_ready = 1'b1;
    logic               busy;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    wallace_sum_sched #(
        .WORDLEN(WORDLEN),
        .CNTW(CNTW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .op_count(op_count),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_sum(out_sum),
        .out_ready(out_ready),
        .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // Scoreboard state: what a frame must produce, derived from the accepted
    // operand stream and the frame length alone.
    int               cyc = 0;
    bit               cont_stream = 1'b1;
    bit               m_busy = 1'b0;
    bit               m_done_seen = 1'b0;
    int               m_rem, m_n, m_start_cyc, m_adds;
    logic [WORDLEN-1:0] m_sum;
    logic [WORDLEN-1:0] last_sum;
    int               last_lat = -1;
    int               last_adds = -1;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("reset_busy", busy, 0);
            check("reset_in_ready", in_ready, 0);
            check("reset_out_valid", out_valid, 0);
            check("reset_out_sum", out_sum, 0);
            m_busy      = 1'b0;
            m_done_seen = 1'b0;
        end else begin
            check("busy", busy, m_busy);
            if (!out_valid) check("out_sum_zero_when_invalid", out_sum, 0);
            if (!m_busy) begin
                check("idle_in_ready", in_ready, 0);
                check("idle_out_valid", out_valid, 0);
                if (start) begin
                    m_busy      = 1'b1;
                    m_done_seen = 1'b0;
                    m_n         = int'(op_count);
                    m_rem       = m_n;
                    m_sum       = '0;
                    m_adds      = 0;
                    m_start_cyc = cyc;
                end
            end else begin
                if (m_rem == 0) check("in_ready_after_last", in_ready, 0);
                if (m_done_seen) check("out_valid_held", out_valid, 1);
                if (busy && !in_ready && !out_valid) m_adds++;
                if (in_valid && in_ready) begin
                    m_sum = m_sum + in_data;
                    m_rem--;
                end
                if (out_valid) begin
                    if (!m_done_seen) begin
                        check("frame_sum", out_sum, m_sum);
                        check("operands_consumed", m_rem, 0);
                        check("tree_passes", m_adds, (m_n + 4) / 5);
                        if (cont_stream)
                            check("latency", cyc - m_start_cyc, m_n + (m_n + 4) / 5 + 1);
                        last_sum    = out_sum;
                        last_lat    = cyc - m_start_cyc;
                        last_adds   = m_adds;
                        m_done_seen = 1'b1;
                    end else begin
                        check("out_sum_held", out_sum, m_sum);
                    end
                    if (out_ready) m_busy = 1'b0;
                end
            end
        end
    end

    logic [WORDLEN-1:0] frame_ops [$];

    task automatic run_frame(input int n, input bit gaps, input int hold,
                             input int abort_after, input bit poke_start);
        int idx = 0;
        int guard = 0;
        @(posedge clk); #1;
        start       = 1'b1;
        op_count    = CNTW'(n);
        cont_stream = !gaps;
        out_ready   = (hold == 0);
        @(posedge clk); #1;
        start    = 1'b0;
        op_count = CNTW'($urandom);
        while (idx < n && guard < 400) begin
            in_valid = gaps ? (guard % 2 == 0) : 1'b1;
            in_data  = in_valid ? frame_ops[idx] : WORDLEN'($urandom);
            if (poke_start && guard == 2) begin
                start    = 1'b1;
                op_count = CNTW'(3);
            end
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
            start = 1'b0;
            guard++;
            if (abort_after >= 0 && idx == abort_after) begin
                in_valid = 1'b0;
                rst_n    = 1'b0;
                #1;
                check("async_reset_busy", busy, 0);
                check("async_reset_in_ready", in_ready, 0);
                check("async_reset_out_valid", out_valid, 0);
                check("async_reset_out_sum", out_sum, 0);
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1'b1;
                return;
            end
        end
        in_valid = 1'b0;
        if (idx < n) begin
            timeout("operand_stream");
            return;
        end
        guard = 0;
        while (!out_valid && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!out_valid) begin
            timeout("out_valid_wait");
            return;
        end
        repeat (hold) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);

        frame_ops = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
        run_frame(5, 1'b0, 0, -1, 1'b0);
        check("n5_sum_literal", last_sum, 15);
        check("n5_latency_literal", last_lat, 7);

        frame_ops.delete();
        repeat (12) frame_ops.push_back(8'h20);
        run_frame(12, 1'b0, 0, -1, 1'b0);
        check("n12_sum_literal", last_sum, 8'h80);
        check("n12_passes_literal", last_adds, 3);
        check("n12_latency_literal", last_lat, 16);

        frame_ops.delete();
        run_frame(0, 1'b0, 0, -1, 1'b0);
        check("n0_sum_literal", last_sum, 0);
        check("n0_latency_literal", last_lat, 1);

        frame_ops = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16};
        run_frame(7, 1'b1, 3, -1, 1'b0);
        check("n7_gapped_sum_literal", last_sum, 8'd91);

        frame_ops = '{8'd50, 8'd60, 8'd70, 8'd80, 8'd90, 8'd100, 8'd110, 8'd120};
        run_frame(8, 1'b0, 0, 3, 1'b0);
        frame_ops = '{8'd9, 8'd9};
        run_frame(2, 1'b0, 0, -1, 1'b0);
        check("post_reset_sum_literal", last_sum, 18);
        check("post_reset_latency_literal", last_lat, 4);

        frame_ops = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        run_frame(8, 1'b0, 0, -1, 1'b1);
        check("ignored_start_sum_literal", last_sum, 36);

        for (int f = 0; f < 14; f++) begin
            int n;
            n = $urandom_range(0, 30);
            frame_ops.delete();
            for (int k = 0; k < n; k++) frame_ops.push_back(WORDLEN'($urandom));
            run_frame(n, 1'($urandom_range(0, 1)), $urandom_range(0, 3), -1, 1'b0);
        end

        frame_ops.delete();
        repeat (127) frame_ops.push_back(8'hFF);
        run_frame(127, 1'b0, 1, -1, 1'b0);
        check("max_frame_sum_literal", last_sum, 8'h81);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
